alu_wb_stage: RTL and testbench

Execute-to-writeback stage directly downstream of the alu. It captures the ALU result and the four status flags (negativo, cero, acarreo, desbordamiento) under a valid/ready handshake and buffers them in a 2-entry skid FIFO. It presents results to the register-file write port and holds the architectural flag register, whose carry bit feeds back to the ALU ci input.

---
 rtl/alu_wb_stage.sv | 121 ++++++++++++
 tb/tb_alu_wb_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: 2-entry skid FIFO of ALU results + flag register.
// Optional perf counters (retire_cnt, stall_cnt) enabled by `define WB_PERF_CNT_EN.
module alu_wb_stage #(
  parameter int WIDTH = 31,
  parameter int RD_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_result,
  input  logic [1:0]       in_opcode,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_set_flags,
  input  logic             in_negativo,
  input  logic             in_cero,
  input  logic             in_acarreo,
  input  logic             in_desbordamiento,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic [3:0]       flags_q,
  output logic             carry_q,
`ifdef WB_PERF_CNT_EN
  output logic [15:0]      retire_cnt,
  output logic [15:0]      stall_cnt,
`endif
  output logic             err_sticky
);

  logic [1:0]      count;
  logic [1:0]      count_nxt;
  logic [WIDTH:0]  skid_result;
  logic [RD_W-1:0] skid_rd;
  logic            acc;
  logic            rsv;
  logic            push;
  logic            pop;

  assign acc       = in_valid & in_ready;
  assign rsv       = (in_opcode == 2'b11);
  assign push      = acc & ~rsv;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign carry_q   = flags_q[1];

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Occupancy and registered ready (ready is low only when both slots are full).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
    end
  end

  // Head register drives out_*; skid slot holds the second entry.
  // When empty the head keeps the last popped values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result  <= '0;
      out_rd      <= '0;
      skid_result <= '0;
      skid_rd     <= '0;
    end else begin
      if (pop && count == 2'd2) begin
        out_result <= skid_result;
        out_rd     <= skid_rd;
      end
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          out_result <= in_result;
          out_rd     <= in_rd;
        end else begin
          skid_result <= in_result;
          skid_rd     <= in_rd;
        end
      end
    end
  end

  // Flags update at acceptance so the next ALU op sees the new carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q    <= 4'b0000;
      err_sticky <= 1'b0;
    end else if (acc) begin
      if (rsv) begin
        err_sticky <= 1'b1;
      end else if (in_set_flags) begin
        flags_q <= {in_negativo, in_cero, in_acarreo, in_desbordamiento};
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  // Retire and upstream-stall counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt <= 16'd0;
      stall_cnt  <= 16'd0;
    end else begin
      if (pop) retire_cnt <= retire_cnt + 16'd1;
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed plan then randomized traffic.
module tb_alu_wb_stage;
  localparam int W  = 31;
  localparam int RW = 4;

  typedef struct packed {
    logic [W:0]    res;
    logic [RW-1:0] rd;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    in_result;
  logic [1:0]    in_opcode;
  logic [RW-1:0] in_rd;
  logic          in_set_flags;
  logic          in_negativo;
  logic          in_cero;
  logic          in_acarreo;
  logic          in_desbordamiento;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    out_result;
  logic [RW-1:0] out_rd;
  logic [3:0]    flags_q;
  logic          carry_q;
  logic          err_sticky;
`ifdef WB_PERF_CNT_EN
  logic [15:0]   retire_cnt;
  logic [15:0]   stall_cnt;
  logic [15:0]   m_ret;
  logic [15:0]   m_stall;
`endif

  ent_t       sb[$];
  ent_t       mlast;
  logic [3:0] mflags;
  logic       merr;
  bit         armed;
  bit         rst_pend;
  int         checks;
  int         errors;

  always #5 clk = ~clk;

  alu_wb_stage #(.WIDTH(W), .RD_W(RW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_opcode(in_opcode),
    .in_rd(in_rd),
    .in_set_flags(in_set_flags),
    .in_negativo(in_negativo),
    .in_cero(in_cero),
    .in_acarreo(in_acarreo),
    .in_desbordamiento(in_desbordamiento),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_rd(out_rd),
    .flags_q(flags_q),
    .carry_q(carry_q),
`ifdef WB_PERF_CNT_EN
    .retire_cnt(retire_cnt),
    .stall_cnt(stall_cnt),
`endif
    .err_sticky(err_sticky)
  );

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, a, e, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      mlast = '0;
`ifdef WB_PERF_CNT_EN
      m_ret = 16'd0;
`endif
    end else if (armed && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {out_result, out_rd}, 64'hffff_ffff_ffff_ffff);
      end else begin
        mlast = sb.pop_front();
        chk("retire_data", {out_result, out_rd}, mlast);
      end
`ifdef WB_PERF_CNT_EN
      m_ret = m_ret + 16'd1;
`endif
    end
  end

  // One cycle: check state after the edge, drive, then record acceptance.
  task automatic step(input bit rst, input bit v, input logic [W:0] r,
                      input logic [1:0] op, input logic [RW-1:0] rd,
                      input bit sf, input logic [3:0] fl, input bit ordy,
                      output bit acc);
    bit m_rdy;
    @(posedge clk);
    #1;
    if (rst_pend) begin
      sb.delete();
      mflags   = 4'b0000;
      merr     = 1'b0;
      rst_pend = 1'b0;
      armed    = 1'b1;
`ifdef WB_PERF_CNT_EN
      m_stall  = 16'd0;
`endif
    end
    m_rdy = (sb.size() != 2);
    if (armed) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      if (sb.size() != 0)
        chk("head", {out_result, out_rd}, sb[0]);
      else
        chk("hold", {out_result, out_rd}, mlast);
      chk("flags_q", {60'd0, flags_q}, {60'd0, mflags});
      chk("carry_q", {63'd0, carry_q}, {63'd0, mflags[1]});
      chk("err_sticky", {63'd0, err_sticky}, {63'd0, merr});
`ifdef WB_PERF_CNT_EN
      chk("retire_cnt", {48'd0, retire_cnt}, {48'd0, m_ret});
      chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, m_stall});
`endif
    end
    rst_n             = rst;
    in_valid          = v;
    in_result         = r;
    in_opcode         = op;
    in_rd             = rd;
    in_set_flags      = sf;
    {in_negativo, in_cero, in_acarreo, in_desbordamiento} = fl;
    out_ready         = ordy;
    acc               = 1'b0;
    @(negedge clk);
    if (!rst) begin
      rst_pend = 1'b1;
    end else if (armed) begin
`ifdef WB_PERF_CNT_EN
      if (v && !m_rdy) m_stall = m_stall + 16'd1;
`endif
      if (v && m_rdy) begin
        acc = 1'b1;
        if (op == 2'b11) merr = 1'b1;
        else begin
          sb.push_back('{res: r, rd: rd});
          if (sf) mflags = fl;
        end
      end
    end
  endtask

  task automatic idle(input bit ordy, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1, 0, '0, 2'b00, '0, 0, 4'h0, ordy, a);
  endtask

  // Holds the transaction until accepted, with a bounded wait.
  task automatic send(input logic [W:0] r, input logic [1:0] op,
                      input logic [RW-1:0] rd, input bit sf,
                      input logic [3:0] fl, input bit ordy);
    bit a;
    int n;
    n = 0;
    a = 1'b0;
    while (!a && n < 20) begin
      step(1, 1, r, op, rd, sf, fl, ordy, a);
      n++;
    end
    if (!a) chk("accept_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    bit a;
    bit v;
    bit ordy;
    logic [1:0] op;
    checks   = 0;
    errors   = 0;
    armed    = 1'b0;
    rst_pend = 1'b0;
    mflags   = 4'b0000;
    merr     = 1'b0;
    mlast    = '0;
`ifdef WB_PERF_CNT_EN
    m_ret    = 16'd0;
    m_stall  = 16'd0;
`endif
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_result = '0;
    in_opcode = 2'b00;
    in_rd = '0;
    in_set_flags = 1'b0;
    {in_negativo, in_cero, in_acarreo, in_desbordamiento} = 4'h0;
    out_ready = 1'b0;

    step(0, 0, '0, 2'b00, '0, 0, 4'h0, 0, a);
    step(0, 0, '0, 2'b00, '0, 0, 4'h0, 0, a);
    idle(1, 1);

    send(32'd9, 2'b00, 4'd1, 1, 4'b0000, 1);
    idle(1, 2);

    send(32'd1, 2'b00, 4'd2, 0, 4'h0, 0);
    send(32'd2, 2'b01, 4'd3, 0, 4'h0, 0);
    step(1, 1, 32'd3, 2'b10, 4'd4, 0, 4'h0, 0, a);
    step(1, 1, 32'd3, 2'b10, 4'd4, 0, 4'h0, 0, a);
    send(32'd3, 2'b10, 4'd4, 0, 4'h0, 1);
    idle(1, 4);

    send(32'd5, 2'b00, 4'd5, 1, 4'b0010, 1);
    send(32'd6, 2'b00, 4'd6, 0, 4'b0000, 1);
    idle(1, 2);

    send(32'hDEAD, 2'b11, 4'd7, 1, 4'b1111, 1);
    idle(1, 2);
    send(32'd7, 2'b01, 4'd8, 1, 4'b1000, 1);
    idle(1, 2);

    send(32'hAAAA_5555, 2'b00, 4'd9, 1, 4'b1111, 0);
    send(32'h5555_AAAA, 2'b00, 4'd10, 1, 4'b1111, 0);
    step(0, 0, '0, 2'b00, '0, 0, 4'h0, 1, a);
    idle(1, 4);

    send(32'd9, 2'b00, 4'd11, 0, 4'h0, 0);
    for (int i = 0; i < 4; i++)
      send(32'(10 + i), 2'b00, 4'(12 + i), 0, 4'h0, 1);
    idle(1, 3);

    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      op   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step(($urandom_range(0, 149) != 0), v, $urandom, op,
           RW'($urandom), $urandom_range(0, 1) == 1, 4'($urandom), ordy, a);
    end
    idle(1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
